// File: rtl/load_align_pipe.sv
// load_align_pipe
//   Load-data aligner/extender between the data-memory read port and the
//   register-file write mux. Picks the addressed byte, half or 32-bit lane
//   out of a DATA_W-bit memory word, sign- or zero-extends it, flags
//   misaligned and illegal loads, and carries a destination tag. A main
//   output register plus one skid register give 1-cycle latency and full
//   throughput under back-pressure.
//
// Ports
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   in_valid    in   load result presented
//   in_ready    out  block can accept (registered)
//   in_mode     in   000 full, 001 lb, 010 lh, 011 lbu, 100 lhu,
//                    101 lw32, 110 lwu, 111 illegal
//   in_addr_lo  in   byte offset within the memory word
//   in_data     in   raw memory word
//   in_tag      in   destination tag
//   out_valid   out  result valid
//   out_ready   in   consumer accepts
//   out_data    out  aligned, extended result (0 on error)
//   out_tag     out  tag of the result
//   out_err     out  bit0 misaligned, bit1 illegal mode
//   err_count   out  saturating count of accepted loads with an error
//   clr_count   in   synchronous clear of err_count (wins over increment)
module load_align_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_mode,
  input  logic [$clog2(DATA_W/8)-1:0]   in_addr_lo,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [TAG_W-1:0]              out_tag,
  output logic [1:0]                    out_err,
  output logic [CNT_W-1:0]              err_count,
  input  logic                          clr_count
);

  localparam int OFS_W = $clog2(DATA_W/8);

  localparam logic [2:0] MODE_FULL = 3'b000;
  localparam logic [2:0] MODE_LB   = 3'b001;
  localparam logic [2:0] MODE_LH   = 3'b010;
  localparam logic [2:0] MODE_LBU  = 3'b011;
  localparam logic [2:0] MODE_LHU  = 3'b100;
  localparam logic [2:0] MODE_LW   = 3'b101;
  localparam logic [2:0] MODE_LWU  = 3'b110;

  // Lane masks; with DATA_W=32 the 32-bit mask is all ones, so lw32/lwu
  // collapse to a plain full-word pass-through.
  localparam logic [DATA_W-1:0] MASK8  = DATA_W'(8'hFF);
  localparam logic [DATA_W-1:0] MASK16 = DATA_W'(16'hFFFF);
  localparam logic [DATA_W-1:0] MASK32 = DATA_W'(32'hFFFF_FFFF);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Keep the lane bits and fill everything above with the sign bit or zero.
  function automatic logic [DATA_W-1:0] extend(
    input logic [DATA_W-1:0] v,
    input logic [DATA_W-1:0] m,
    input logic              sign_bit,
    input logic              signed_mode
  );
    if (signed_mode && sign_bit) begin
      extend = v | ~m;
    end else begin
      extend = v & m;
    end
  endfunction

  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_lane;
  logic              w_misalign;
  logic              w_illegal;
  logic [1:0]        w_err;
  logic [DATA_W-1:0] w_result;
  logic              w_in_fire;
  logic              w_out_fire;

  logic              r_in_ready;
  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [TAG_W-1:0]  r_main_tag;
  logic [1:0]        r_main_err;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [TAG_W-1:0]  r_skid_tag;
  logic [1:0]        r_skid_err;
  logic [CNT_W-1:0]  r_err_count;

  // Move the addressed byte to bit 0 so every lane starts at the LSB.
  assign w_shift = in_data >> {in_addr_lo, 3'b000};

  // Lane selection, extension and alignment/illegal-mode checks.
  always_comb begin
    w_lane     = {DATA_W{1'b0}};
    w_misalign = 1'b0;
    w_illegal  = 1'b0;
    case (in_mode)
      MODE_FULL: begin
        w_lane     = in_data;
        w_misalign = (in_addr_lo != {OFS_W{1'b0}});
      end
      MODE_LB:  w_lane = extend(w_shift, MASK8, w_shift[7], 1'b1);
      MODE_LBU: w_lane = extend(w_shift, MASK8, w_shift[7], 1'b0);
      MODE_LH: begin
        w_lane     = extend(w_shift, MASK16, w_shift[15], 1'b1);
        w_misalign = in_addr_lo[0];
      end
      MODE_LHU: begin
        w_lane     = extend(w_shift, MASK16, w_shift[15], 1'b0);
        w_misalign = in_addr_lo[0];
      end
      MODE_LW: begin
        w_lane     = extend(w_shift, MASK32, w_shift[31], 1'b1);
        w_misalign = (in_addr_lo[1:0] != 2'b00);
      end
      MODE_LWU: begin
        w_lane     = extend(w_shift, MASK32, w_shift[31], 1'b0);
        w_misalign = (in_addr_lo[1:0] != 2'b00);
      end
      default: w_illegal = 1'b1;
    endcase
    w_err = {w_illegal, w_misalign};
    if (w_err != 2'b00) begin
      w_result = {DATA_W{1'b0}};
    end else begin
      w_result = w_lane;
    end
  end

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_main_valid & out_ready;

  // Main/skid pipeline. in_ready is simply "skid will be empty", registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_ready   <= 1'b1;
      r_main_valid <= 1'b0;
      r_main_data  <= {DATA_W{1'b0}};
      r_main_tag   <= {TAG_W{1'b0}};
      r_main_err   <= 2'b00;
      r_skid_valid <= 1'b0;
      r_skid_data  <= {DATA_W{1'b0}};
      r_skid_tag   <= {TAG_W{1'b0}};
      r_skid_err   <= 2'b00;
    end else if (!r_main_valid || w_out_fire) begin
      // Main slot frees up: oldest pending entry (skid first) moves in.
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        r_main_tag   <= r_skid_tag;
        r_main_err   <= r_skid_err;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main_data  <= w_result;
        r_main_tag   <= in_tag;
        r_main_err   <= w_err;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      // Main stalled: park the new result in the skid slot and close input.
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_result;
      r_skid_tag   <= in_tag;
      r_skid_err   <= w_err;
      r_in_ready   <= 1'b0;
    end else begin
      r_skid_valid <= r_skid_valid;
    end
  end

  // Saturating error counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= {CNT_W{1'b0}};
    end else if (clr_count) begin
      r_err_count <= {CNT_W{1'b0}};
    end else if (w_in_fire && (w_err != 2'b00) && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_tag   = r_main_tag;
  assign out_err   = r_main_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_load_align_pipe.sv
// Directed bench for load_align_pipe: a 32-bit instance for lane/extension,
// back-pressure, streaming and reset, and a 64-bit instance with a 2-bit
// error counter for wide lanes and counter saturation/clear.
module tb_load_align_pipe;

  logic clk;
  logic reset_n;

  // 32-bit instance
  logic        v32, rdy32, ov32, or32, clr32;
  logic [2:0]  m32;
  logic [1:0]  o32;
  logic [31:0] d32, od32;
  logic [4:0]  t32, ot32;
  logic [1:0]  oe32;
  logic [15:0] ec32;

  // 64-bit instance
  logic        v64, rdy64, ov64, or64, clr64;
  logic [2:0]  m64;
  logic [2:0]  o64;
  logic [63:0] d64, od64;
  logic [4:0]  t64, ot64;
  logic [1:0]  oe64;
  logic [1:0]  ec64;

  int n_checks = 0;
  int n_err    = 0;

  load_align_pipe #(.DATA_W(32), .TAG_W(5), .CNT_W(16)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v32), .in_ready(rdy32), .in_mode(m32), .in_addr_lo(o32),
    .in_data(d32), .in_tag(t32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_tag(ot32),
    .out_err(oe32), .err_count(ec32), .clr_count(clr32)
  );

  load_align_pipe #(.DATA_W(64), .TAG_W(5), .CNT_W(2)) dut64 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v64), .in_ready(rdy64), .in_mode(m64), .in_addr_lo(o64),
    .in_data(d64), .in_tag(t64),
    .out_valid(ov64), .out_ready(or64), .out_data(od64), .out_tag(ot64),
    .out_err(oe64), .err_count(ec64), .clr_count(clr64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One load on the 32-bit instance: present at a negedge, fires on the
  // next rising edge, result visible at the following negedge.
  task automatic drive32(input logic [2:0] m, input logic [1:0] o,
                         input logic [31:0] d, input logic [4:0] t);
    v32 = 1'b1; m32 = m; o32 = o; d32 = d; t32 = t;
    @(negedge clk);
    v32 = 1'b0;
  endtask

  task automatic drive64(input logic [2:0] m, input logic [2:0] o,
                         input logic [63:0] d, input logic [4:0] t);
    v64 = 1'b1; m64 = m; o64 = o; d64 = d; t64 = t;
    @(negedge clk);
    v64 = 1'b0;
  endtask

  // Independent reference for 32-bit loads: returns {err, data}.
  function automatic logic [33:0] ref32(input logic [2:0] m, input logic [1:0] o,
                                        input logic [31:0] d);
    logic [7:0]  by [4];
    logic [7:0]  b;
    logic [15:0] h;
    logic [1:0]  e;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
    b = by[o];
    h = {by[o + 2'd1], by[o]};
    e = 2'b00;
    r = d;
    case (m)
      3'd0, 3'd5, 3'd6: begin r = d; e[0] = (o != 2'd0); end
      3'd1: r = {{24{b[7]}}, b};
      3'd2: begin r = {{16{h[15]}}, h}; e[0] = o[0]; end
      3'd3: r = {24'd0, b};
      3'd4: begin r = {16'd0, h}; e[0] = o[0]; end
      default: e = 2'b10;
    endcase
    if (e != 2'b00) r = 32'd0;
    return {e, r};
  endfunction

  logic [38:0] q[$];

  task automatic set_stream_inputs(input int nin, input int n, input bit rnd);
    v32  = (nin < n) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
    m32  = 3'($urandom_range(7));
    o32  = 2'($urandom_range(3));
    d32  = $urandom;
    t32  = 5'($urandom_range(31));
    or32 = rnd ? 1'($urandom_range(1)) : 1'b1;
  endtask

  // Stream n loads through the 32-bit instance, scoreboarding every output.
  task automatic stream(input int n, input bit rnd, output int cycles);
    int nin, nout;
    logic [38:0] e;
    nin = 0; nout = 0; cycles = 0;
    set_stream_inputs(nin, n, rnd);
    while (nout < n && cycles < 2000) begin
      if (ov32 && or32) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("stream_data", {32'd0, od32}, {32'd0, e[31:0]});
          chk("stream_err",  {62'd0, oe32}, {62'd0, e[33:32]});
          chk("stream_tag",  {59'd0, ot32}, {59'd0, e[38:34]});
        end else begin
          chk("stream_extra_output", 64'd1, {63'd0, q.size() > 0});
        end
        nout++;
      end
      if (v32 && rdy32) begin
        q.push_back({t32, ref32(m32, o32, d32)});
        nin++;
      end
      cycles++;
      @(posedge clk);
      #1;
      if (nout < n) set_stream_inputs(nin, n, rnd);
      @(negedge clk);
    end
    chk("stream_done", 64'(nout), 64'(n));
    v32 = 1'b0; or32 = 1'b1;
    @(negedge clk);
  endtask

  localparam logic [31:0] D32 = 32'h8899_AABB;
  localparam logic [63:0] D64 = 64'h8000_0001_7FFF_FFFE;

  initial begin
    int cyc;
    reset_n = 1'b0;
    v32 = 1'b0; or32 = 1'b1; clr32 = 1'b0; m32 = 3'd0; o32 = 2'd0; d32 = 32'd0; t32 = 5'd0;
    v64 = 1'b0; or64 = 1'b1; clr64 = 1'b0; m64 = 3'd0; o64 = 3'd0; d64 = 64'd0; t64 = 5'd0;
    #12;
    chk("rst_out_valid", {63'd0, ov32}, 64'd0);
    chk("rst_in_ready",  {63'd0, rdy32}, 64'd1);
    chk("rst_out_data",  {32'd0, od32}, 64'd0);
    chk("rst_err_count", {48'd0, ec32}, 64'd0);
    chk("rst_out_tag",   {59'd0, ot32}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Lane extraction and extension, 1-cycle latency
    drive32(3'b001, 2'd0, D32, 5'd1);
    chk("lb0_valid", {63'd0, ov32}, 64'd1);
    chk("lb0_data", {32'd0, od32}, {32'd0, 32'hFFFF_FFBB});
    chk("lb0_err", {62'd0, oe32}, 64'd0);
    chk("lb0_tag", {59'd0, ot32}, 64'd1);
    drive32(3'b011, 2'd3, D32, 5'd2);
    chk("lbu3_data", {32'd0, od32}, {32'd0, 32'h0000_0088});
    drive32(3'b010, 2'd2, D32, 5'd4);
    chk("lh2_data", {32'd0, od32}, {32'd0, 32'hFFFF_8899});
    drive32(3'b100, 2'd2, D32, 5'd5);
    chk("lhu2_data", {32'd0, od32}, {32'd0, 32'h0000_8899});
    drive32(3'b000, 2'd0, D32, 5'd6);
    chk("full0_data", {32'd0, od32}, {32'd0, D32});

    // Errors
    drive32(3'b010, 2'd1, D32, 5'd3);
    chk("lh1_data", {32'd0, od32}, 64'd0);
    chk("lh1_err", {62'd0, oe32}, 64'd1);
    chk("lh1_tag", {59'd0, ot32}, 64'd3);
    chk("lh1_cnt", {48'd0, ec32}, 64'd1);
    drive32(3'b111, 2'd0, D32, 5'd7);
    chk("ill_data", {32'd0, od32}, 64'd0);
    chk("ill_err", {62'd0, oe32}, 64'd2);
    chk("ill_tag", {59'd0, ot32}, 64'd7);
    chk("ill_cnt", {48'd0, ec32}, 64'd2);
    @(negedge clk);
    chk("drained_valid", {63'd0, ov32}, 64'd0);

    // Back-pressure: tags 1,2,3 with out_ready low
    or32 = 1'b0;
    v32 = 1'b1; m32 = 3'b000; o32 = 2'd0; d32 = 32'h1111_1111; t32 = 5'd1;
    @(negedge clk);
    chk("bp_ready_after1", {63'd0, rdy32}, 64'd1);
    d32 = 32'h2222_2222; t32 = 5'd2;
    @(negedge clk);
    chk("bp_ready_low", {63'd0, rdy32}, 64'd0);
    chk("bp_main_tag", {59'd0, ot32}, 64'd1);
    d32 = 32'h3333_3333; t32 = 5'd3;
    @(negedge clk);
    chk("bp_still_low", {63'd0, rdy32}, 64'd0);
    chk("bp_hold_tag", {59'd0, ot32}, 64'd1);
    chk("bp_hold_data", {32'd0, od32}, 64'h1111_1111);
    or32 = 1'b1;
    @(negedge clk);
    chk("bp_out2_tag", {59'd0, ot32}, 64'd2);
    chk("bp_ready_back", {63'd0, rdy32}, 64'd1);
    @(negedge clk);
    v32 = 1'b0;
    chk("bp_out3_tag", {59'd0, ot32}, 64'd3);
    chk("bp_out3_data", {32'd0, od32}, 64'h3333_3333);
    @(negedge clk);
    chk("bp_empty", {63'd0, ov32}, 64'd0);

    // Streaming: full rate, then random handshakes
    stream(100, 1'b0, cyc);
    chk("stream_cycles", 64'(cyc), 64'd101);
    stream(100, 1'b1, cyc);

    // 64-bit lanes
    drive64(3'b101, 3'd4, D64, 5'd8);
    chk("w64_lw4", od64, 64'hFFFF_FFFF_8000_0001);
    drive64(3'b110, 3'd4, D64, 5'd9);
    chk("w64_lwu4", od64, 64'h0000_0000_8000_0001);
    drive64(3'b010, 3'd6, D64, 5'd10);
    chk("w64_lh6", od64, 64'hFFFF_FFFF_FFFF_8000);
    drive64(3'b101, 3'd2, D64, 5'd11);
    chk("w64_lw2_err", {62'd0, oe64}, 64'd1);
    chk("w64_lw2_data", od64, 64'd0);
    chk("w64_cnt1", {62'd0, ec64}, 64'd1);
    drive64(3'b111, 3'd0, D64, 5'd12);
    drive64(3'b111, 3'd0, D64, 5'd13);
    chk("w64_cnt3", {62'd0, ec64}, 64'd3);
    drive64(3'b111, 3'd0, D64, 5'd14);
    chk("w64_cnt_sat", {62'd0, ec64}, 64'd3);
    chk("w64_sat_tag", {59'd0, ot64}, 64'd14);
    clr64 = 1'b1;
    drive64(3'b111, 3'd0, D64, 5'd15);
    clr64 = 1'b0;
    chk("w64_clr_wins", {62'd0, ec64}, 64'd0);

    // Async reset with both entries full
    or32 = 1'b0;
    v32 = 1'b1; m32 = 3'b000; o32 = 2'd0; d32 = 32'hAAAA_0001; t32 = 5'd9;
    @(negedge clk);
    d32 = 32'hAAAA_0002; t32 = 5'd10;
    @(negedge clk);
    v32 = 1'b0;
    chk("full_ready_low", {63'd0, rdy32}, 64'd0);
    chk("full_valid", {63'd0, ov32}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, ov32}, 64'd0);
    chk("arst_in_ready", {63'd0, rdy32}, 64'd1);
    chk("arst_out_data", {32'd0, od32}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    or32 = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", {63'd0, ov32}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
